// File: rtl/uart_chat_pkg.sv
// Shared types and sizing for the UART chat transmit path.
package uart_chat_pkg;

  localparam int unsigned MSG_BYTES = 8;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned MSG_W     = MSG_BYTES * BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_SENT
  } state_t;

  // Byte counts above the message capacity are treated as a full message.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MSG_BYTES)) ? LEN_W'(MSG_BYTES) : len;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the source not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] pick
);

  always_comb begin
    pick    = '0;
    pick[0] = req[0] & (~req[1] | last_grant);
    pick[1] = req[1] & (~req[0] | ~last_grant);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte interface between two message sources, sending each
// granted message MSB-first with a per-byte watchdog on the sent handshake.
module uart_tx_arbiter
  import uart_chat_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              req_1,
  input  logic [MSG_W-1:0]  msg_0,
  input  logic [MSG_W-1:0]  msg_1,
  input  logic [LEN_W-1:0]  len_0,
  input  logic [LEN_W-1:0]  len_1,
  output logic              grant_0,
  output logic              grant_1,
  output logic              done_0,
  output logic              done_1,
  output logic              error_0,
  output logic              error_1,
  output logic [BYTE_W-1:0] Byte_Out,
  output logic              Load_Byte,
  input  logic              byte_has_been_sent,
  output logic              busy
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t             state, state_next;
  logic [MSG_W-1:0]   shift;
  logic [LEN_W-1:0]   byte_count, byte_total;
  logic [TIMER_W-1:0] timer;
  logic               owner, last_grant;
  logic [1:0]         pick;
  logic [1:0]         grant_n, done_n, error_n;
  logic [LEN_W-1:0]   sel_len;
  logic [MSG_W-1:0]   sel_msg;
  logic               timeout_hit;

  rr_arbiter2 u_rr (
    .req        ({req_1, req_0}),
    .last_grant (last_grant),
    .pick       (pick)
  );

  assign sel_len = clamp_len(pick[1] ? len_1 : len_0);
  assign sel_msg = pick[1] ? msg_1 : msg_0;
  // Fires on the last permitted WAIT_SENT cycle, so the watchdog allows exactly TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign busy = (state == LOAD) || (state == WAIT_SENT);

  always_comb begin
    state_next = state;
    grant_n    = '0;
    done_n     = '0;
    error_n    = '0;
    case (state)
      IDLE: begin
        if (pick != 2'b00) begin
          grant_n = pick;
          if (sel_len == '0) done_n = pick;
          else               state_next = LOAD;
        end
      end
      LOAD: state_next = WAIT_SENT;
      WAIT_SENT: begin
        if (byte_has_been_sent) begin
          if (byte_count == byte_total) begin
            done_n[owner] = 1'b1;
            state_next    = IDLE;
          end else begin
            state_next = LOAD;
          end
        end else if (timeout_hit) begin
          error_n[owner] = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      shift      <= '0;
      byte_count <= '0;
      byte_total <= '0;
      timer      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      grant_0    <= 1'b0;
      grant_1    <= 1'b0;
      done_0     <= 1'b0;
      done_1     <= 1'b0;
      error_0    <= 1'b0;
      error_1    <= 1'b0;
      Byte_Out   <= '0;
      Load_Byte  <= 1'b0;
    end else begin
      state     <= state_next;
      grant_0   <= grant_n[0];
      grant_1   <= grant_n[1];
      done_0    <= done_n[0];
      done_1    <= done_n[1];
      error_0   <= error_n[0];
      error_1   <= error_n[1];
      Load_Byte <= 1'b0;
      case (state)
        IDLE: begin
          if (pick != 2'b00) begin
            shift      <= sel_msg;
            byte_total <= sel_len;
            byte_count <= '0;
            owner      <= pick[1];
            last_grant <= pick[1];
          end
        end
        LOAD: begin
          Byte_Out   <= shift[MSG_W-1 -: BYTE_W];
          Load_Byte  <= 1'b1;
          shift      <= shift << BYTE_W;
          byte_count <= byte_count + LEN_W'(1);
          timer      <= '0;
        end
        WAIT_SENT: begin
          if (!byte_has_been_sent && (timer != '1)) timer <= timer + TIMER_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a delayed-ack UART responder.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_0, req_1;
  logic [63:0] msg_0, msg_1;
  logic [3:0]  len_0, len_1;
  logic        grant_0, grant_1, done_0, done_1, error_0, error_1;
  logic [7:0]  Byte_Out;
  logic        Load_Byte;
  logic        byte_has_been_sent;
  logic        busy;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_0              (req_0),
    .req_1              (req_1),
    .msg_0              (msg_0),
    .msg_1              (msg_1),
    .len_0              (len_0),
    .len_1              (len_1),
    .grant_0            (grant_0),
    .grant_1            (grant_1),
    .done_0             (done_0),
    .done_1             (done_1),
    .error_0            (error_0),
    .error_1            (error_1),
    .Byte_Out           (Byte_Out),
    .Load_Byte          (Load_Byte),
    .byte_has_been_sent (byte_has_been_sent),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] bytes_q[$];
  int load_cyc[$];
  int grants_q[$];
  int dones_q[$];
  int errs_q[$];
  int grant_cyc, done_cyc, error_cyc;
  int gd_same, clash;

  bit ack_en    = 1'b1;
  int ack_delay = 3;
  int cd        = 0;
  bit hold_0    = 1'b0;
  bit hold_1    = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observe registered outputs mid-cycle.
  initial forever begin
    @(negedge clk);
    if (Load_Byte) begin bytes_q.push_back(Byte_Out); load_cyc.push_back(cyc); end
    if (grant_0) begin grants_q.push_back(0); grant_cyc = cyc; end
    if (grant_1) begin grants_q.push_back(1); grant_cyc = cyc; end
    if (done_0)  begin dones_q.push_back(0); done_cyc = cyc; end
    if (done_1)  begin dones_q.push_back(1); done_cyc = cyc; end
    if (error_0) begin errs_q.push_back(0); error_cyc = cyc; end
    if (error_1) begin errs_q.push_back(1); error_cyc = cyc; end
    if ((grant_0 && done_0) || (grant_1 && done_1)) gd_same++;
    if ((grant_0 | done_0 | error_0) && (grant_1 | done_1 | error_1)) clash++;
  end

  // UART model: pulse byte_has_been_sent so it is sampled ack_delay+1 edges after Load_Byte.
  initial begin
    byte_has_been_sent = 1'b0;
    forever begin
      @(negedge clk);
      byte_has_been_sent = 1'b0;
      if (!reset) cd = 0;
      else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) byte_has_been_sent = 1'b1;
        end
        if (Load_Byte && ack_en) cd = ack_delay;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    if (grant_0 && !hold_0) req_0 = 1'b0;
    if (grant_1 && !hold_1) req_1 = 1'b0;
  endtask

  task automatic clear_logs();
    bytes_q.delete(); load_cyc.delete(); grants_q.delete();
    dones_q.delete(); errs_q.delete();
    gd_same = 0;
  endtask

  function automatic int count_of(input int which);
    case (which)
      0: return load_cyc.size();
      1: return grants_q.size();
      2: return dones_q.size();
      default: return errs_q.size();
    endcase
  endfunction

  task automatic wait_count(input string tag, input int which, input int target);
    int n = 0;
    while (count_of(which) < target && n < 400) begin tick(); n++; end
    if (count_of(which) < target) check({tag, "_timeout"}, 64'(count_of(which)), 64'(target));
  endtask

  function automatic logic [63:0] packed_bytes();
    logic [63:0] r = '0;
    foreach (bytes_q[i]) r = (r << 8) | 64'(bytes_q[i]);
    return r;
  endfunction

  function automatic logic [63:0] grant_code();
    logic [63:0] r = '0;
    foreach (grants_q[i]) r = (r << 4) | 64'(grants_q[i]);
    return r;
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int req_cyc;

  initial begin
    reset = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
    msg_0 = '0; msg_1 = '0; len_0 = '0; len_1 = '0;
    gd_same = 0; clash = 0;
    cycles(3);
    check("reset_outputs", {grant_0, grant_1, done_0, done_1, error_0, error_1, Load_Byte, busy, Byte_Out}, '0);
    reset = 1'b1;
    cycles(2);

    // Single 8-byte message from source 0
    clear_logs();
    msg_0 = 64'h6869_2074_6865_7265; len_0 = 4'd8;
    req_0 = 1'b1; req_cyc = cyc + 1;
    wait_count("single", 2, 1);
    check("single_grant_lat", 64'(grant_cyc), 64'(req_cyc));
    check("single_nloads", 64'(load_cyc.size()), 64'd8);
    check("single_bytes", packed_bytes(), 64'h6869_2074_6865_7265);
    check("single_done_src", 64'(dones_q[0]), 64'd0);
    check("single_no_err", 64'(errs_q.size()), 64'd0);
    if (load_cyc.size() == 8) begin
      check("single_first_load", 64'(load_cyc[0]), 64'(req_cyc + 1));
      check("single_byte_gap", 64'(load_cyc[1] - load_cyc[0]), 64'd5);
      check("single_done_lat", 64'(done_cyc - load_cyc[7]), 64'd4);
    end
    cycles(2);
    check("single_idle", 64'(busy), 64'd0);

    // Contention from reset: source 0 first, then source 1
    reset = 1'b0;
    msg_0 = 64'h1122_0000_0000_0000; len_0 = 4'd2;
    msg_1 = 64'h3344_0000_0000_0000; len_1 = 4'd2;
    req_0 = 1'b1; req_1 = 1'b1;
    cycles(3);
    clear_logs();
    reset = 1'b1;
    wait_count("contend", 2, 2);
    check("contend_order", grant_code(), 64'h01);
    check("contend_bytes", packed_bytes(), 64'h1122_3344);
    cycles(3);

    clear_logs();
    hold_0 = 1'b1; hold_1 = 1'b1; req_0 = 1'b1; req_1 = 1'b1;
    wait_count("alt", 2, 4);
    req_0 = 1'b0; req_1 = 1'b0; hold_0 = 1'b0; hold_1 = 1'b0;
    check("alt_order", grant_code(), 64'h0101);
    check("alt_dones", 64'(dones_q.size()), 64'd4);
    cycles(12);

    // Short and empty messages
    clear_logs();
    msg_1 = 64'hA1B2_C3D4_E5F6_0718; len_1 = 4'd3; req_1 = 1'b1;
    wait_count("short", 2, 1);
    check("short_nloads", 64'(load_cyc.size()), 64'd3);
    check("short_bytes", packed_bytes(), 64'hA1B2C3);
    cycles(2);

    clear_logs();
    len_1 = 4'd0; req_1 = 1'b1;
    wait_count("empty", 2, 1);
    cycles(3);
    check("empty_grant_done", 64'(gd_same), 64'd1);
    check("empty_nloads", 64'(load_cyc.size()), 64'd0);
    check("empty_done_src", 64'(dones_q[0]), 64'd1);

    clear_logs();
    msg_0 = 64'h0102_0304_0506_0708; len_0 = 4'd12; req_0 = 1'b1;
    wait_count("clamp", 2, 1);
    check("clamp_nloads", 64'(load_cyc.size()), 64'd8);
    check("clamp_bytes", packed_bytes(), 64'h0102_0304_0506_0708);
    cycles(2);

    // Watchdog: no handshake on source 0, source 1 queued behind it
    clear_logs();
    ack_en = 1'b0;
    msg_0 = 64'hC0DE_0000_0000_0000; len_0 = 4'd2; req_0 = 1'b1;
    wait_count("wd_grant", 1, 1);
    msg_1 = 64'h5A00_0000_0000_0000; len_1 = 4'd1; req_1 = 1'b1;
    wait_count("wd", 3, 1);
    check("wd_err_src", 64'(errs_q[0]), 64'd0);
    check("wd_err_time", 64'(error_cyc - load_cyc[0]), 64'd16);
    check("wd_nloads", 64'(load_cyc.size()), 64'd1);
    check("wd_no_done", 64'(dones_q.size()), 64'd0);
    ack_en = 1'b1;
    wait_count("wd_next", 2, 1);
    check("wd_next_order", grant_code(), 64'h01);
    check("wd_next_done", 64'(dones_q[0]), 64'd1);
    check("wd_bytes", packed_bytes(), 64'hC05A);
    cycles(3);

    // Handshake lands in the timeout cycle
    clear_logs();
    ack_delay = 15;
    msg_0 = 64'hBEEF_0000_0000_0000; len_0 = 4'd2; req_0 = 1'b1;
    wait_count("race", 2, 1);
    check("race_no_err", 64'(errs_q.size()), 64'd0);
    check("race_bytes", packed_bytes(), 64'hBEEF);
    check("race_gap", 64'(load_cyc[1] - load_cyc[0]), 64'd17);
    ack_delay = 3;
    cycles(3);

    // Reset in the middle of a transfer
    clear_logs();
    msg_0 = 64'hDEAD_BEEF_0011_2233; len_0 = 4'd8; req_0 = 1'b1;
    wait_count("rst_loads", 0, 2);
    reset = 1'b0;
    tick();
    check("rst_outputs", {grant_0, grant_1, done_0, done_1, error_0, error_1, Load_Byte, busy, Byte_Out}, '0);
    reset = 1'b1;
    cycles(8);
    check("rst_no_done_err", 64'(dones_q.size() + errs_q.size()), 64'd0);
    clear_logs();
    msg_1 = 64'h7788_0000_0000_0000; len_1 = 4'd2; req_1 = 1'b1; req_cyc = cyc + 1;
    wait_count("rst_next", 2, 1);
    check("rst_next_grant", grant_code(), 64'h1);
    check("rst_next_lat", 64'(grant_cyc), 64'(req_cyc));
    check("rst_next_bytes", packed_bytes(), 64'h7788);
    check("rst_next_no_err", 64'(errs_q.size()), 64'd0);
    cycles(3);

    check("pulse_exclusive", 64'(clash), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
